seg7_time_logger: RTL and testbench

Receive-side companion to the stopwatch display path: takes the four active-low 7-segment digit buses (MM:SS), decodes them back to BCD, and filters out transient patterns. Each new stable displayed time is logged into a small show-ahead FIFO for a downstream reader (UART dumper or lap recorder). It sits on the same `clk` as the stopwatch, directly on the HEX wires.

---
 rtl/seg7_logger_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_time_logger.sv | 172 +++++++++++++++++
 tb/tb_seg7_time_logger.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_logger_pkg.sv
// Shared definitions for the 7-segment time logger: segment patterns, FSM states, entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Build option: SEG7_LOGGER_SEQNUM_EN widens stored entries to carry an 8-bit sequence number.
package seg7_logger_pkg;

  // Active-low segment patterns, bit0 = segment a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } entry_t;

`ifdef SEG7_LOGGER_SEQNUM_EN
  localparam int ENTRY_W = 24;
`else
  localparam int ENTRY_W = 16;
`endif

endpackage

// File: rtl/seg7_decode.sv
// Decodes one active-low 7-segment digit back to BCD (blank -> 4'hF); flags unknown patterns.
// Latency: combinational.
// Backpressure: none.
// Ports: i_seg (7b segments), o_digit (4b BCD or BLANK_DIGIT), o_valid (pattern recognised).
module seg7_decode
  import seg7_logger_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_valid
);

  always_comb begin
    o_digit = 4'h0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_digit = BLANK_DIGIT;
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_time_logger.sv
// Snoops MM:SS HEX wires, debounces each new displayed time and logs it into a show-ahead FIFO.
// Latency: stable input to rd_valid is STABLE_CYCLES+2 clocks; pop takes effect at the clock edge.
// Backpressure: none on HEX; commits arriving while full (without a same-cycle pop) are dropped and flag overflow.
// Ports: clk, RST (sync, active-high), HEX0..HEX3 (SecL, SecH, MinL, MinH), rd_en;
//        rd_valid, rd_data, count, full, overflow (sticky), bad_pattern (sticky).
// Build option: SEG7_LOGGER_SEQNUM_EN adds an 8-bit commit sequence number in rd_data[23:16].
module seg7_time_logger
  import seg7_logger_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [6:0]               HEX0,
  input  logic [6:0]               HEX1,
  input  logic [6:0]               HEX2,
  input  logic [6:0]               HEX3,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     bad_pattern
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    STAB_C  = 8'(STABLE_CYCLES);

  // ---------------- input stage ----------------
  // Reset to the 00:00 pattern so the idle display right after reset matches r_last.
  logic [27:0] r_hex;
  always_ff @(posedge clk) begin
    if (RST) r_hex <= {SEG_0, SEG_0, SEG_0, SEG_0};
    else     r_hex <= {HEX3, HEX2, HEX1, HEX0};
  end

  entry_t     w_sample;
  logic [3:0] w_dvalid;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_decode u_dec (
      .i_seg   (r_hex[7*g +: 7]),
      .o_digit (w_sample[4*g +: 4]),
      .o_valid (w_dvalid[g])
    );
  end

  logic w_valid;
  assign w_valid = &w_dvalid;

  // ---------------- FSM ----------------
  state_t     r_state, w_next;
  entry_t     r_cand, r_last;
  logic [7:0] r_stab;
  logic [7:0] w_stab_inc;
  logic       w_same_cand, w_same_last;
  logic       w_load_cand, w_inc_stab, w_commit;

  assign w_stab_inc  = r_stab + 8'd1;
  assign w_same_cand = (w_sample == r_cand);
  assign w_same_last = (w_sample == r_last);

  always_ff @(posedge clk) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid && !w_same_last) w_next = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_valid || w_same_last)              w_next = ST_IDLE;
        else if (w_same_cand && w_stab_inc == STAB_C) w_next = ST_COMMIT;
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load_cand = 1'b0;
    w_inc_stab  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE:   w_load_cand = w_valid && !w_same_last;
      ST_SETTLE: begin
        if (w_valid && !w_same_last) begin
          if (w_same_cand) w_inc_stab  = 1'b1;
          else             w_load_cand = 1'b1;
        end
      end
      ST_COMMIT: w_commit = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_cand <= '0;
      r_stab <= 8'd0;
      r_last <= '0;
    end else begin
      if (w_load_cand) begin
        r_cand <= w_sample;
        r_stab <= 8'd1;
      end else if (w_inc_stab) begin
        r_stab <= w_stab_inc;
      end
      if (w_commit) r_last <= r_cand;
    end
  end

  // ---------------- FIFO ----------------
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [ENTRY_W-1:0] w_wr_dat;
  logic               w_full, w_pop, w_push, w_drop;

`ifdef SEG7_LOGGER_SEQNUM_EN
  // Counts every commit, dropped ones included, so readers can spot gaps.
  logic [7:0] r_seq;
  always_ff @(posedge clk) begin
    if (RST)           r_seq <= 8'd0;
    else if (w_commit) r_seq <= r_seq + 8'd1;
  end
  assign w_wr_dat = {r_seq, r_cand};
`else
  assign w_wr_dat = r_cand;
`endif

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = rd_en && (r_count != '0);
  // A pop in the same cycle frees the slot, so a commit into a full FIFO still lands.
  assign w_push = w_commit && (!w_full || w_pop);
  assign w_drop = w_commit && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_dat;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      overflow    <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      if (w_drop)   overflow    <= 1'b1;
      if (!w_valid) bad_pattern <= 1'b1;
    end
  end

  assign rd_valid = (r_count != '0);
  assign rd_data  = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = w_full;

endmodule

// File: tb/tb_seg7_time_logger.sv
// Directed bench for seg7_time_logger: reset, latency, glitch filtering, fill/overflow, push+pop when full, wrap, reset flush.
// Latency: inputs driven 1 time unit after posedge, outputs checked at the same point after later edges.
// Backpressure: rd_en is driven explicitly per pop.
module tb_seg7_time_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RST;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic        rd_en;
  logic        rd_valid;
`ifdef SEG7_LOGGER_SEQNUM_EN
  logic [23:0] rd_data;
`else
  logic [15:0] rd_data;
`endif
  logic [3:0]  count;
  logic        full, overflow, bad_pattern;

  int checks = 0;
  int errors = 0;

  seg7_time_logger #(.STABLE_CYCLES(4), .DEPTH(8)) dut (
    .clk         (clk),
    .RST         (RST),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .bad_pattern (bad_pattern)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      4'hF: return 7'h7F;
      default: return 7'h7E;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [15:0] t);
    HEX3 = seg(t[15:12]);
    HEX2 = seg(t[11:8]);
    HEX1 = seg(t[7:4]);
    HEX0 = seg(t[3:0]);
  endtask

  // Hold a time long enough to be committed and for the FSM to return to IDLE.
  task automatic log_time(input logic [15:0] t);
    set_time(t);
    tick(8);
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    set_time(16'h0000);
    RST = 1'b1;
    tick(2);
    checks++; if (count !== 4'd0)      begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (bad_pattern !== 1'b0) begin errors++; $display("FAIL reset_bad got %b want 0", bad_pattern); end
    RST = 1'b0;
    tick(10);
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL idle_0000_logged rd_valid got %b want 0", rd_valid); end
    checks++; if (bad_pattern !== 1'b0) begin errors++; $display("FAIL idle_bad got %b want 0", bad_pattern); end
  endtask

  task automatic test_single;
    set_time(16'h0001);
    tick(5);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL latency_early rd_valid got %b want 0", rd_valid); end
    tick(1);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL latency_6 rd_valid got %b want 1", rd_valid); end
    checks++; if (rd_data[15:0] !== 16'h0001) begin errors++; $display("FAIL single_data got %h want 0001", rd_data[15:0]); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    pop_one();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop rd_valid got %b want 0", rd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_pop count got %0d want 0", count); end
  endtask

  task automatic test_glitch;
    // 3-cycle glitch: one short of STABLE_CYCLES, must not commit.
    set_time(16'h0002);
    tick(3);
    set_time(16'h0001);
    tick(10);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_logged rd_valid got %b want 0", rd_valid); end
    HEX0 = 7'h7E;
    tick(1);
    checks++; if (bad_pattern !== 1'b0) begin errors++; $display("FAIL bad_early got %b want 0", bad_pattern); end
    HEX0 = seg(4'd1);
    tick(1);
    checks++; if (bad_pattern !== 1'b1) begin errors++; $display("FAIL bad_set got %b want 1", bad_pattern); end
    tick(8);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bad_logged rd_valid got %b want 0", rd_valid); end
    log_time(16'hF001);
    checks++; if (rd_data[15:0] !== 16'hF001 || rd_valid !== 1'b1) begin errors++; $display("FAIL blank_data got %h/%b want F001/1", rd_data[15:0], rd_valid); end
    pop_one();
  endtask

  task automatic test_fill;
    set_time(16'h0000);
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      log_time(16'(i));
      if (i == 8) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fill8 full/ovf got %b/%b want 1/0", full, overflow); end
      end
    end
    checks++; if (count !== 4'd8)    begin errors++; $display("FAIL fill_count got %0d want 8", count); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'(i)) begin errors++; $display("FAIL fill_read%0d got %h/%b want %h/1", i, rd_data[15:0], rd_valid, 16'(i)); end
`ifdef SEG7_LOGGER_SEQNUM_EN
      checks++; if (rd_data[23:16] !== 8'(i - 1)) begin errors++; $display("FAIL fill_seq%0d got %0d want %0d", i, rd_data[23:16], i - 1); end
`endif
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_drain rd_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_back_to_back;
    set_time(16'h0000);
    do_reset();
    for (int i = 1; i <= 8; i++) log_time(16'(i));
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL b2b_prefill count got %0d want 8", count); end
    // Commit edge lands 6 edges after the change; pop on that same edge.
    set_time(16'h0009);
    tick(5);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    checks++; if (count !== 4'd8)    begin errors++; $display("FAIL b2b_count got %0d want 8", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL b2b_full got %b want 1", full); end
    for (int i = 2; i <= 9; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'(i)) begin errors++; $display("FAIL b2b_read%0d got %h/%b want %h/1", i, rd_data[15:0], rd_valid, 16'(i)); end
`ifdef SEG7_LOGGER_SEQNUM_EN
      checks++; if (rd_data[23:16] !== 8'(i - 1)) begin errors++; $display("FAIL b2b_seq%0d got %0d want %0d", i, rd_data[23:16], i - 1); end
`endif
      pop_one();
    end
  endtask

  task automatic test_wrap_and_reset;
    set_time(16'h0000);
    do_reset();
    log_time(16'h5959);
    checks++; if (rd_data[15:0] !== 16'h5959) begin errors++; $display("FAIL wrap_5959 got %h want 5959", rd_data[15:0]); end
    pop_one();
    log_time(16'h0000);
    checks++; if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_0000 got %h/%b want 0000/1", rd_data[15:0], rd_valid); end
    pop_one();
    HEX0 = 7'h7E;
    tick(1);
    HEX0 = seg(4'd0);
    tick(1);
    checks++; if (bad_pattern !== 1'b1) begin errors++; $display("FAIL wrap_bad got %b want 1", bad_pattern); end
    log_time(16'h0001);
    log_time(16'h0002);
    log_time(16'h0003);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL queued3 count got %0d want 3", count); end
    RST = 1'b1;
    tick(1);
    checks++; if (count !== 4'd0)       begin errors++; $display("FAIL rst_flush count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0)    begin errors++; $display("FAIL rst_flush rd_valid got %b want 0", rd_valid); end
    checks++; if (full !== 1'b0)        begin errors++; $display("FAIL rst_flush full got %b want 0", full); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_flush overflow got %b want 0", overflow); end
    checks++; if (bad_pattern !== 1'b0) begin errors++; $display("FAIL rst_flush bad got %b want 0", bad_pattern); end
    RST = 1'b0;
    tick(2);
  endtask

  initial begin
    RST   = 1'b1;
    rd_en = 1'b0;
    set_time(16'h0000);
    tick(1);
    test_reset();
    test_single();
    test_glitch();
    test_fill();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
